// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/load-store memory access arbiter.
package mem_arb_pkg;

  localparam int unsigned LAT_CNT_W = 4;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_priority_select.sv
// Combinational winner selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: alternate on contention using last_owner; otherwise data always wins.
module mem_arb_priority_select
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_owner,
  output logic grant_c,
  output logic winner_c
);

  logic contend_winner_c;

`ifdef ARB_ROUND_ROBIN_EN
  // The requester not served most recently takes the contended slot.
  assign contend_winner_c = (last_owner == OWNER_D) ? OWNER_IF : OWNER_D;
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign contend_winner_c  = OWNER_D;
`endif

  always_comb begin
    grant_c  = if_req | d_req;
    winner_c = OWNER_IF;
    if (if_req && d_req) begin
      winner_c = contend_winner_c;
    end else if (d_req) begin
      winner_c = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one word-wide memory port between instruction fetch and load/store, one access at a time.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data-over-fetch priority.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

  state_t                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic                   owner_d;
  logic                   mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_d;
  logic                   if_ack_d, d_ack_d;
  logic [DATA_W-1:0]      if_rdata_d, d_rdata_d;
  logic                   busy_d;
  logic                   grant_c, winner_c;
  logic                   last_owner;

  mem_arb_priority_select u_select (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .grant_c    (grant_c),
    .winner_c   (winner_c)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was granted last so contention alternates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWNER_IF;
    end else if (state_q == ST_IDLE && grant_c) begin
      last_owner <= winner_c;
    end
  end
`else
  assign last_owner = OWNER_IF;
`endif

  // Next-state and next-output decode; every output leaves through a register.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    owner_d     = owner;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;

    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          state_d   = ST_ACCESS;
          lat_cnt_d = '0;
          owner_d   = winner_c;
          mem_en_d  = 1'b1;
          if (winner_c == OWNER_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = if_addr;
          end
        end
      end
      ST_ACCESS: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = ST_RESP;
          if (owner == OWNER_D) begin
            d_ack_d = 1'b1;
            if (!mem_we) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
          mem_en_d  = 1'b1;
          mem_we_d  = mem_we;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      owner     <= OWNER_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner     <= owner_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_ack    <= if_ack_d;
      d_ack     <= d_ack_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter with a latency-accurate memory model.
module tb_mem_access_arbiter;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 3;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mem [64];
  int en_cnt;

  mem_access_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data valid only in the last access cycle, garbage otherwise.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[0] <= 32'hE412_1000;
      mem[2] <= 32'hE043_3001;
      en_cnt <= 0;
    end else begin
      if (mem_en && mem_we && en_cnt == int'(MEM_LAT) - 1) mem[mem_addr[7:2]] <= mem_wdata;
      en_cnt <= mem_en ? en_cnt + 1 : 0;
    end
  end

  assign mem_rdata = (mem_en && en_cnt == int'(MEM_LAT) - 1) ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

  task automatic wait_ack(input bit want_d, input int max_cyc, output int cyc,
                          output int we_cyc, output int other_acks);
    cyc = -1;
    we_cyc = 0;
    other_acks = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (mem_we) we_cyc++;
      if (want_d ? if_ack : d_ack) other_acks++;
      if (want_d ? d_ack : if_ack) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({busy, owner, mem_en, mem_we, if_ack, d_ack} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, owner, mem_en, mem_we, if_ack, d_ack});
    end
    total++;
    if (if_rdata !== 32'h0) begin bad++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    total++;
    if (d_rdata !== 32'h0) begin bad++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    total++;
    if (mem_addr !== 8'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++;
    if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
  endtask

  task automatic test_fetch();
    int cyc, we, oth;
    if_addr = 8'h00; if_req = 1'b1;
    wait_ack(1'b0, 20, cyc, we, oth);
    if_req = 1'b0;
    total++;
    if (cyc != 4) begin bad++; $display("FAIL fetch_latency: got %0d want 4", cyc); end
    total++;
    if (if_rdata !== 32'hE412_1000) begin bad++; $display("FAIL fetch_data: got %h want e4121000", if_rdata); end
    total++;
    if (oth != 0 || we != 0) begin bad++; $display("FAIL fetch_side: d_acks %0d we_cycles %0d want 0 0", oth, we); end
    @(negedge clk);
    total++;
    if ({if_ack, busy} !== 2'b00) begin bad++; $display("FAIL fetch_pulse: got %b want 00", {if_ack, busy}); end
  endtask

  task automatic test_store_load();
    int cyc, we, oth;
    d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    wait_ack(1'b1, 20, cyc, we, oth);
    d_req = 1'b0; d_we = 1'b0;
    total++;
    if (cyc != 4) begin bad++; $display("FAIL store_latency: got %0d want 4", cyc); end
    total++;
    if (we != 3) begin bad++; $display("FAIL store_we_cycles: got %0d want 3", we); end
    total++;
    if (d_rdata !== 32'h0) begin bad++; $display("FAIL store_keeps_rdata: got %h want 0", d_rdata); end
    @(negedge clk);
    d_addr = 8'h10; d_req = 1'b1;
    wait_ack(1'b1, 20, cyc, we, oth);
    d_req = 1'b0;
    total++;
    if (cyc != 4) begin bad++; $display("FAIL load_latency: got %0d want 4", cyc); end
    total++;
    if (we != 0) begin bad++; $display("FAIL load_we_cycles: got %0d want 0", we); end
    total++;
    if (d_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data: got %h want deadbeef", d_rdata); end
  endtask

  task automatic test_early_drop();
    int cyc, we, oth;
    @(negedge clk);
    d_we = 1'b0; d_addr = 8'h08; d_req = 1'b1;
    @(negedge clk);
    d_req = 1'b0; d_addr = 8'h00;
    wait_ack(1'b1, 20, cyc, we, oth);
    total++;
    if (cyc != 3) begin bad++; $display("FAIL early_latency: got %0d want 3", cyc); end
    total++;
    if (d_rdata !== 32'hE043_3001) begin bad++; $display("FAIL early_data: got %h want e0433001", d_rdata); end
    @(negedge clk);
    total++;
    if ({busy, d_ack} !== 2'b00) begin bad++; $display("FAIL early_regrant: got %b want 00", {busy, d_ack}); end
  endtask

  task automatic test_contention();
    int cyc, we, oth, gap, dual;
    logic [3:0] exp_own;
    logic got;
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = 4'b0101;
`else
    exp_own = 4'b1111;
`endif
    do_reset();
    if_addr = 8'h00; d_addr = 8'h08; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, owner} !== 2'b11) begin bad++; $display("FAIL contend_first_owner: got %b want 11", {busy, owner}); end
    wait_ack(1'b1, 20, cyc, we, oth);
    d_req = 1'b0;
    total++;
    if (cyc != 3 || oth != 0) begin bad++; $display("FAIL contend_d_ack: cyc %0d if_acks %0d want 3 0", cyc, oth); end
    total++;
    if (d_rdata !== 32'hE043_3001) begin bad++; $display("FAIL contend_d_data: got %h want e0433001", d_rdata); end
    wait_ack(1'b0, 20, cyc, we, oth);
    if_req = 1'b0;
    total++;
    if (cyc != 5 || oth != 0) begin bad++; $display("FAIL contend_if_ack: cyc %0d d_acks %0d want 5 0", cyc, oth); end
    total++;
    if (if_rdata !== 32'hE412_1000) begin bad++; $display("FAIL contend_if_data: got %h want e4121000", if_rdata); end

    // Both requesters hold req across acks, so every grant is contended.
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1;
    dual = 0;
    for (int r = 0; r < 4; r++) begin
      gap = -1;
      got = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (if_ack && d_ack) dual++;
        if (if_ack || d_ack) begin
          gap = i;
          got = d_ack;
          break;
        end
      end
      total++;
      if (got !== exp_own[r]) begin bad++; $display("FAIL contend_order%0d: got %b want %b", r, got, exp_own[r]); end
      total++;
      if (gap != ((r == 0) ? 4 : 5)) begin
        bad++; $display("FAIL contend_gap%0d: got %0d want %0d", r, gap, (r == 0) ? 4 : 5);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    total++;
    if (dual != 0) begin bad++; $display("FAIL contend_dual_ack: got %0d want 0", dual); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, we, oth, stray;
    d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'h1234_5678; d_req = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, mem_en, mem_we} !== 3'b111) begin bad++; $display("FAIL midrst_active: got %b want 111", {busy, mem_en, mem_we}); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, mem_en, mem_we, d_ack} !== 4'b0) begin
      bad++; $display("FAIL midrst_async: got %b want 0000", {busy, mem_en, mem_we, d_ack});
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_ack || d_ack || busy) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL midrst_no_ack: got %0d want 0", stray); end
    if_addr = 8'h08; if_req = 1'b1;
    wait_ack(1'b0, 20, cyc, we, oth);
    if_req = 1'b0;
    total++;
    if (cyc != 4) begin bad++; $display("FAIL midrst_next_latency: got %0d want 4", cyc); end
    total++;
    if (if_rdata !== 32'hE043_3001) begin bad++; $display("FAIL midrst_next_data: got %h want e0433001", if_rdata); end
  endtask

  task automatic test_back_to_back();
    int n_ack, first, last;
    @(negedge clk);
    if_addr = 8'h00; if_req = 1'b1;
    n_ack = 0; first = -1; last = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (if_ack) begin
        n_ack++;
        if (first < 0) first = i;
        last = i;
      end
    end
    if_req = 1'b0;
    total++;
    if (n_ack != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", n_ack); end
    total++;
    if (first != 4 || last != 19) begin bad++; $display("FAIL b2b_spacing: first %0d last %0d want 4 19", first, last); end
    total++;
    if (if_rdata !== 32'hE412_1000) begin bad++; $display("FAIL b2b_data: got %h want e4121000", if_rdata); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_release: got %b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_fetch();
    test_store_load();
    test_early_drop();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
